// File: rtl/bus_arbiter_2m.sv
// rtl/bus_arbiter_2m.sv - two-master fixed-latency bus arbiter with burst fairness and lock
module bus_arbiter_2m #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_m0,
    input  logic              req_m1,
    input  logic              lock_m0,
    input  logic              lock_m1,
    input  logic              we_m0,
    input  logic              we_m1,
    input  logic [ADDR_W-1:0] addr_m0,
    input  logic [ADDR_W-1:0] addr_m1,
    input  logic [DATA_W-1:0] wd_m0,
    input  logic [DATA_W-1:0] wd_m1,
    output logic              gnt_m0,
    output logic              gnt_m1,
    output logic              rvalid_m0,
    output logic              rvalid_m1,
    output logic [DATA_W-1:0] rd_m0,
    output logic [DATA_W-1:0] rd_m1,
    output logic              we_s,
    output logic [ADDR_W-1:0] addr_s,
    output logic [DATA_W-1:0] wd_s,
    input  logic [DATA_W-1:0] rd_s
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

    logic [1:0] r_owner;
    logic [3:0] r_cnt;
    logic       r_last;
    logic       r_rvalid_m0;
    logic       r_rvalid_m1;

    logic       w_gnt_m0;
    logic       w_gnt_m1;
    logic       w_burst_ok;
    logic [3:0] w_cnt_inc;

    // The current owner may keep the bus while it is still under its burst allowance.
    assign w_burst_ok = (r_cnt < LP_MAX_BURST);
    assign w_cnt_inc  = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

    // Grant decision: owner keeps the bus on lock, no contention or remaining burst;
    // from IDLE a tie goes to the master that was not granted most recently.
    always_comb begin
        w_gnt_m0 = 1'b0;
        w_gnt_m1 = 1'b0;
        if (!reset) begin
            case (r_owner)
                ST_OWN0: begin
                    if (req_m0 && (lock_m0 || !req_m1 || w_burst_ok)) begin
                        w_gnt_m0 = 1'b1;
                    end else if (req_m1) begin
                        w_gnt_m1 = 1'b1;
                    end
                end
                ST_OWN1: begin
                    if (req_m1 && (lock_m1 || !req_m0 || w_burst_ok)) begin
                        w_gnt_m1 = 1'b1;
                    end else if (req_m0) begin
                        w_gnt_m0 = 1'b1;
                    end
                end
                default: begin
                    if (req_m0 && req_m1) begin
                        w_gnt_m0 = r_last;
                        w_gnt_m1 = ~r_last;
                    end else begin
                        w_gnt_m0 = req_m0;
                        w_gnt_m1 = req_m1;
                    end
                end
            endcase
        end
    end

    // Ownership, burst count and last-granted tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_last  <= 1'b1;
        end else if (w_gnt_m0) begin
            r_owner <= ST_OWN0;
            r_last  <= 1'b0;
            r_cnt   <= (r_owner == ST_OWN0) ? w_cnt_inc : 4'd1;
        end else if (w_gnt_m1) begin
            r_owner <= ST_OWN1;
            r_last  <= 1'b1;
            r_cnt   <= (r_owner == ST_OWN1) ? w_cnt_inc : 4'd1;
        end else begin
            r_owner <= ST_IDLE;
            r_cnt   <= 4'd0;
        end
    end

    // Read data returns one cycle after a read grant; writes produce no rvalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid_m0 <= 1'b0;
            r_rvalid_m1 <= 1'b0;
        end else begin
            r_rvalid_m0 <= w_gnt_m0 & ~we_m0;
            r_rvalid_m1 <= w_gnt_m1 & ~we_m1;
        end
    end

    assign gnt_m0    = w_gnt_m0;
    assign gnt_m1    = w_gnt_m1;
    assign rvalid_m0 = r_rvalid_m0;
    assign rvalid_m1 = r_rvalid_m1;
    assign rd_m0     = r_rvalid_m0 ? rd_s : '0;
    assign rd_m1     = r_rvalid_m1 ? rd_s : '0;

    assign we_s   = (w_gnt_m0 & we_m0) | (w_gnt_m1 & we_m1);
    assign addr_s = w_gnt_m0 ? addr_m0 : (w_gnt_m1 ? addr_m1 : '0);
    assign wd_s   = w_gnt_m0 ? wd_m0 : (w_gnt_m1 ? wd_m1 : '0);

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// tb/tb_bus_arbiter_2m.sv - self-checking bench for bus_arbiter_2m
module tb_bus_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          q_req  [2];
    logic          q_lock [2];
    logic          q_we   [2];
    logic [AW-1:0] q_addr [2];
    logic [DW-1:0] q_wd   [2];

    logic          gnt_m0, gnt_m1, rvalid_m0, rvalid_m1, we_s;
    logic [DW-1:0] rd_m0, rd_m1, wd_s;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] rd_s = '0;

    always #5 clk = ~clk;

    bus_arbiter_2m #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .req_m0(q_req[0]), .req_m1(q_req[1]),
        .lock_m0(q_lock[0]), .lock_m1(q_lock[1]),
        .we_m0(q_we[0]), .we_m1(q_we[1]),
        .addr_m0(q_addr[0]), .addr_m1(q_addr[1]),
        .wd_m0(q_wd[0]), .wd_m1(q_wd[1]),
        .gnt_m0(gnt_m0), .gnt_m1(gnt_m1),
        .rvalid_m0(rvalid_m0), .rvalid_m1(rvalid_m1),
        .rd_m0(rd_m0), .rd_m1(rd_m1),
        .we_s(we_s), .addr_s(addr_s), .wd_s(wd_s), .rd_s(rd_s)
    );

    // Synchronous slave memory behind the interconnect port.
    logic [DW-1:0] slave_mem [0:63];
    logic [DW-1:0] ref_mem   [0:63];

    always @(posedge clk) begin
        if (we_s) slave_mem[addr_s[7:2]] <= wd_s;
        rd_s <= slave_mem[addr_s[7:2]];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: who holds the bus, how many consecutive grants it has had,
    // who was granted last, and the read data expected next cycle.
    int            m_holder;
    int            m_run;
    int            m_last;
    bit            e_rv [2];
    logic [DW-1:0] e_rd [2];
    int            cur_g;

    logic          o_g0, o_g1, o_we, o_rv1;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wd, o_rd1;

    task automatic model_reset();
        m_holder = -1;
        m_run    = 0;
        m_last   = 1;
        e_rv[0]  = 0;
        e_rv[1]  = 0;
    endtask

    function automatic int pick();
        if (reset) return -1;
        if (!q_req[0] && !q_req[1]) return -1;
        if (q_req[0] && !q_req[1]) return 0;
        if (q_req[1] && !q_req[0]) return 1;
        if (m_holder < 0) return 1 - m_last;
        if (q_lock[m_holder] || m_run < MB) return m_holder;
        return 1 - m_holder;
    endfunction

    task automatic check_cycle();
        logic          x_we;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wd;
        int g;
        g = pick();
        cur_g = g;
        x_we = 1'b0; x_addr = '0; x_wd = '0;
        if (g >= 0) begin
            x_we = q_we[g]; x_addr = q_addr[g]; x_wd = q_wd[g];
        end
        o_g0 = gnt_m0; o_g1 = gnt_m1; o_we = we_s; o_addr = addr_s; o_wd = wd_s;
        o_rv1 = rvalid_m1; o_rd1 = rd_m1;
        check("gnt_m0", gnt_m0, 64'(g == 0));
        check("gnt_m1", gnt_m1, 64'(g == 1));
        check("we_s", we_s, x_we);
        check("addr_s", addr_s, x_addr);
        check("wd_s", wd_s, x_wd);
        check("rvalid_m0", rvalid_m0, e_rv[0]);
        check("rvalid_m1", rvalid_m1, e_rv[1]);
        check("rd_m0", rd_m0, e_rv[0] ? e_rd[0] : '0);
        check("rd_m1", rd_m1, e_rv[1] ? e_rd[1] : '0);
    endtask

    task automatic model_update(input int g);
        e_rv[0] = 0;
        e_rv[1] = 0;
        if (reset) begin
            model_reset();
        end else if (g >= 0) begin
            e_rv[g] = !q_we[g];
            e_rd[g] = ref_mem[q_addr[g][7:2]];
            if (q_we[g]) ref_mem[q_addr[g][7:2]] = q_wd[g];
            m_run    = (m_holder == g) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
            m_holder = g;
            m_last   = g;
        end else begin
            m_holder = -1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        model_update(cur_g);
    endtask

    task automatic set_m(input int m, input logic rq, input logic lk, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        q_req[m] = rq; q_lock[m] = lk; q_we[m] = w; q_addr[m] = a; q_wd[m] = d;
    endtask

    logic [11:0] pat;
    int          ngr;

    initial begin
        for (int i = 0; i < 64; i++) begin
            slave_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
            ref_mem[i]   = 32'h1000_0000 + i * 32'h0101_0101;
        end
        model_reset();
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h0000_1000, '0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h0001_0000, '0);

        // Requests held during reset must produce no grants.
        tick();
        tick();
        reset = 1'b0;

        // First tie after reset goes to m0, read data one cycle later.
        tick();
        check("first_tie_m0", o_g0, 1'b1);
        q_req[0] = 1'b0;
        tick();
        q_req[1] = 1'b0;
        tick();
        tick();

        // Continuous contention: bursts of MAX_BURST alternating, no gaps.
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, '0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h0000_0080, '0);
        pat = '0; ngr = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            pat = {pat[10:0], o_g1};
            ngr += int'(o_g0 | o_g1);
        end
        check("burst_pattern", pat, 12'b0000_1111_0000);
        check("burst_no_gap", ngr, 12);
        q_req[0] = 1'b0; q_req[1] = 1'b0;
        tick();
        tick();

        // Lock held by m0 for six cycles overrides the burst limit.
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, '0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h0000_0020, '0);
        pat = '0;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) q_lock[0] = 1'b0;
            tick();
            pat = {pat[10:0], o_g1};
        end
        check("lock_pattern", pat, 12'b0000_0000_0001);
        q_req[0] = 1'b0; q_req[1] = 1'b0;
        tick();
        tick();

        // m1 write then read-back of the same word.
        set_m(1, 1'b1, 1'b0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
        tick();
        check("wr_we_s", o_we, 1'b1);
        check("wr_wd_s", o_wd, 32'hDEAD_BEEF);
        q_we[1] = 1'b0;
        tick();
        q_req[1] = 1'b0;
        tick();
        check("rd_rvalid_m1", o_rv1, 1'b1);
        check("rd_data_m1", o_rd1, 32'hDEAD_BEEF);

        // Idle cycles, then an m1-only request is granted at once.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_no_gnt", o_g0 | o_g1, 1'b0);
            check("idle_addr", o_addr, '0);
        end
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h0000_0008, '0);
        tick();
        check("m1_only_gnt", o_g1, 1'b1);

        // Reset in the cycle after a read grant kills the pending rvalid immediately.
        check("rv_before_rst", rvalid_m1, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_rvalid_m1", rvalid_m1, 1'b0);
        check("rst_rd_m1", rd_m1, '0);
        check("rst_gnt_m1", gnt_m1, 1'b0);
        model_reset();
        tick();
        reset = 1'b0;
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h0000_000C, '0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h0000_0014, '0);
        tick();
        check("post_rst_tie_m0", o_g0, 1'b1);
        q_req[0] = 1'b0;
        q_req[1] = 1'b0;
        tick();

        // Random traffic: each master holds its transaction until granted.
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (cur_g == m) q_req[m] = 1'b0;
                if (!q_req[m] && $urandom_range(0, 9) < 6) begin
                    q_req[m]  = 1'b1;
                    q_we[m]   = $urandom_range(0, 2) == 0;
                    q_addr[m] = ($urandom() & 32'hFFFF_00FC);
                    q_wd[m]   = $urandom();
                end
                q_lock[m] = ($urandom_range(0, 7) == 0);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
